// File: rtl/mips_decode_pkg.sv
// mips_decode_pkg
//   Shared definitions for the MIPS32 instruction-decode slice:
//   opcode constants, ALUOp encodings, ID/EX control-bus bit positions,
//   the packed control struct and the main control decoder function.
//   Imported by decode_stage_if, register_file and decode_stage.
package mips_decode_pkg;

  localparam int NUM_REGS  = 32;
  localparam int REG_IDX_W = $clog2(NUM_REGS);
  localparam int CTRL_W    = 8;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

  // Bit positions inside ID_EX_Ctrl, MSB first:
  // {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp[1:0]}
  localparam int CTRL_REG_DST    = 7;
  localparam int CTRL_ALU_SRC    = 6;
  localparam int CTRL_MEM_TO_REG = 5;
  localparam int CTRL_REG_WRITE  = 4;
  localparam int CTRL_MEM_READ   = 3;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_ALU_OP_LSB = 0;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] alu_op;
  } ctrl_t;

  // Main control decoder. Unknown opcodes become an all-zero NOP.
  // A jump carries no datapath control either, so it maps to zero
  // whether or not jump support is built in.
  function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
    logic [CTRL_W-1:0] v;
    v = '0;
    case (opcode)
      OP_R: begin
        v[CTRL_REG_DST]                = 1'b1;
        v[CTRL_REG_WRITE]              = 1'b1;
        v[CTRL_ALU_OP_LSB +: 2]        = ALU_OP_RTYPE;
      end
      OP_LW: begin
        v[CTRL_ALU_SRC]                = 1'b1;
        v[CTRL_MEM_TO_REG]             = 1'b1;
        v[CTRL_REG_WRITE]              = 1'b1;
        v[CTRL_MEM_READ]               = 1'b1;
        v[CTRL_ALU_OP_LSB +: 2]        = ALU_OP_ADD;
      end
      OP_SW: begin
        v[CTRL_ALU_SRC]                = 1'b1;
        v[CTRL_MEM_WRITE]              = 1'b1;
        v[CTRL_ALU_OP_LSB +: 2]        = ALU_OP_ADD;
      end
      OP_ADDI: begin
        v[CTRL_ALU_SRC]                = 1'b1;
        v[CTRL_REG_WRITE]              = 1'b1;
        v[CTRL_ALU_OP_LSB +: 2]        = ALU_OP_ADD;
      end
      OP_BEQ: begin
        v[CTRL_ALU_OP_LSB +: 2]        = ALU_OP_SUB;
      end
      OP_J:    v = '0;
      default: v = '0;
    endcase
    return ctrl_t'(v);
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if
//   ID/EX pipeline-register bundle produced by decode_stage.
//   master : decode_stage (drives the registered ID/EX fields)
//   slave  : execute stage (consumes them)
//   Signals: ID_EX_PC_plus4, ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm (32 each),
//            ID_EX_Rs, ID_EX_Rt, ID_EX_Rd (5 each), ID_EX_Ctrl (CTRL_W).
interface decode_stage_if;
  import mips_decode_pkg::*;

  logic [31:0]          ID_EX_PC_plus4;
  logic [31:0]          ID_EX_ReadData1;
  logic [31:0]          ID_EX_ReadData2;
  logic [31:0]          ID_EX_Imm;
  logic [REG_IDX_W-1:0] ID_EX_Rs;
  logic [REG_IDX_W-1:0] ID_EX_Rt;
  logic [REG_IDX_W-1:0] ID_EX_Rd;
  logic [CTRL_W-1:0]    ID_EX_Ctrl;

  modport master (
    output ID_EX_PC_plus4, ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm,
    output ID_EX_Rs, ID_EX_Rt, ID_EX_Rd, ID_EX_Ctrl
  );

  modport slave (
    input ID_EX_PC_plus4, ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm,
    input ID_EX_Rs, ID_EX_Rt, ID_EX_Rd, ID_EX_Ctrl
  );

endinterface

// File: rtl/register_file.sv
// register_file
//   NUM_REGS x 32 register file, two combinational read ports, one write port.
//   Register 0 is hardwired to zero. A read of the register being written in
//   the same cycle returns the incoming write data, so writeback and decode
//   can share a cycle without a separate forwarding path.
//   Ports: clk, rst (async, active-low, clears all entries),
//          we/waddr/wdata (write port), raddr1/rdata1, raddr2/rdata2 (read ports).
module register_file
  import mips_decode_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] waddr,
  input  logic [31:0]          wdata,
  input  logic [REG_IDX_W-1:0] raddr1,
  output logic [31:0]          rdata1,
  input  logic [REG_IDX_W-1:0] raddr2,
  output logic [31:0]          rdata2
);

  logic [31:0] regs [NUM_REGS];
  logic        write_live;

  assign write_live = we && (waddr != '0);

  // Storage update; entry 0 is never written so it stays at its reset value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (write_live) begin
      regs[waddr] <= wdata;
    end
  end

  // Write-first read: a same-cycle write to the addressed entry wins.
  assign rdata1 = (raddr1 == '0)                    ? 32'h0 :
                  (write_live && (waddr == raddr1)) ? wdata : regs[raddr1];
  assign rdata2 = (raddr2 == '0)                    ? 32'h0 :
                  (write_live && (waddr == raddr2)) ? wdata : regs[raddr2];

endmodule

// File: rtl/decode_stage.sv
// decode_stage
//   Instruction-decode stage of the 5-stage MIPS32 pipeline: register file,
//   main control decode, load-use / branch hazard detection, early beq
//   resolution and the ID/EX pipeline register.
//   Ports:
//     clk, rst (async, active-low)
//     IF_ID_PC_plus4, IF_ID_Instruction : from fetch
//     WB_RegWrite, WB_WriteReg, WB_WriteData : writeback port of the regfile
//     EX_MemRead, EX_RegWrite, EX_WriteReg, MEM_MemRead, MEM_WriteReg : hazard inputs
//     HoldPC, Hold_data : stall fetch;  IF_ID_Flush, PCSrc, branch_target : redirect
//     id_ex : registered ID/EX bundle (decode_stage_if.master)
//   Build option: define DECODE_JUMP_EN to decode opcode 0x02 (j) as an
//   unconditional redirect; otherwise it is treated as an unknown opcode.
module decode_stage
  import mips_decode_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          IF_ID_PC_plus4,
  input  logic [31:0]          IF_ID_Instruction,
  input  logic                 WB_RegWrite,
  input  logic [REG_IDX_W-1:0] WB_WriteReg,
  input  logic [31:0]          WB_WriteData,
  input  logic                 EX_MemRead,
  input  logic                 EX_RegWrite,
  input  logic [REG_IDX_W-1:0] EX_WriteReg,
  input  logic                 MEM_MemRead,
  input  logic [REG_IDX_W-1:0] MEM_WriteReg,
  output logic                 HoldPC,
  output logic                 Hold_data,
  output logic                 IF_ID_Flush,
  output logic                 PCSrc,
  output logic [31:0]          branch_target,
  decode_stage_if.master       id_ex
);

  logic [5:0]           opcode;
  logic [REG_IDX_W-1:0] rs, rt, rd;
  logic [31:0]          imm;
  logic [31:0]          read_data1, read_data2;
  ctrl_t                ctrl;
  logic                 is_beq, is_jump;
  logic                 ex_dep, mem_dep;
  logic                 load_use_stall, branch_stall, stall;
  logic                 beq_taken;
  logic [31:0]          beq_target, jump_target;

  assign opcode = IF_ID_Instruction[31:26];
  assign rs     = IF_ID_Instruction[25:21];
  assign rt     = IF_ID_Instruction[20:16];
  assign rd     = IF_ID_Instruction[15:11];
  assign imm    = {{16{IF_ID_Instruction[15]}}, IF_ID_Instruction[15:0]};
  assign ctrl   = decode_ctrl(opcode);
  assign is_beq = (opcode == OP_BEQ);

`ifdef DECODE_JUMP_EN
  assign is_jump = (opcode == OP_J);
`else
  assign is_jump = 1'b0;
`endif

  register_file u_register_file (
    .clk    (clk),
    .rst    (rst),
    .we     (WB_RegWrite),
    .waddr  (WB_WriteReg),
    .wdata  (WB_WriteData),
    .raddr1 (rs),
    .rdata1 (read_data1),
    .raddr2 (rt),
    .rdata2 (read_data2)
  );

  // A producer in EX/MEM matters only if it targets a real register that
  // this instruction names as rs or rt.
  assign ex_dep  = (EX_WriteReg  != '0) && ((EX_WriteReg  == rs) || (EX_WriteReg  == rt));
  assign mem_dep = (MEM_WriteReg != '0) && ((MEM_WriteReg == rs) || (MEM_WriteReg == rt));

  // beq compares in ID, so it must also wait for any ALU result still in EX
  // and for a load still in MEM; a jump reads no registers and never waits.
  assign load_use_stall = EX_MemRead && ex_dep;
  assign branch_stall   = is_beq && ((EX_RegWrite && ex_dep) || (MEM_MemRead && mem_dep));
  assign stall          = !is_jump && (load_use_stall || branch_stall);

  assign beq_taken   = is_beq && !stall && (read_data1 == read_data2);
  assign beq_target  = IF_ID_PC_plus4 + (imm << 2);
  assign jump_target = {IF_ID_PC_plus4[31:28], IF_ID_Instruction[25:0], 2'b00};

  assign HoldPC        = stall;
  assign Hold_data     = stall;
  assign PCSrc         = beq_taken || is_jump;
  assign IF_ID_Flush   = beq_taken || is_jump;
  assign branch_target = is_jump ? jump_target : beq_target;

  // ID/EX register loads every cycle; a stall only turns the control field
  // into a bubble so nothing downstream writes state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_ex.ID_EX_PC_plus4  <= '0;
      id_ex.ID_EX_ReadData1 <= '0;
      id_ex.ID_EX_ReadData2 <= '0;
      id_ex.ID_EX_Imm       <= '0;
      id_ex.ID_EX_Rs        <= '0;
      id_ex.ID_EX_Rt        <= '0;
      id_ex.ID_EX_Rd        <= '0;
      id_ex.ID_EX_Ctrl      <= '0;
    end else begin
      id_ex.ID_EX_PC_plus4  <= IF_ID_PC_plus4;
      id_ex.ID_EX_ReadData1 <= read_data1;
      id_ex.ID_EX_ReadData2 <= read_data2;
      id_ex.ID_EX_Imm       <= imm;
      id_ex.ID_EX_Rs        <= rs;
      id_ex.ID_EX_Rt        <= rt;
      id_ex.ID_EX_Rd        <= rd;
      id_ex.ID_EX_Ctrl      <= stall ? '0 : ctrl;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage
//   Self-checking bench for decode_stage: directed scenarios followed by
//   randomized instructions, compared against a behavioural model that
//   keeps its own register array and derives control words from a table.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc4, instr;
  logic        wb_we;
  logic [4:0]  wb_wr;
  logic [31:0] wb_data;
  logic        ex_mr, ex_rw, mem_mr;
  logic [4:0]  ex_wr, mem_wr;
  logic        hold_pc, hold_data, flush, pcsrc;
  logic [31:0] target;

  int checks = 0;
  int passes = 0;

  logic [31:0] mreg [32];

  // Expected values for the instruction currently presented
  logic        e_stall, e_pcsrc;
  logic [31:0] e_target, e_rd1, e_rd2, e_imm, e_pc4;
  logic [4:0]  e_rs, e_rt, e_rd;
  logic [7:0]  e_ctrl;

  always #5 clk = ~clk;

  decode_stage_if idex ();

  decode_stage dut (
    .clk               (clk),
    .rst               (rst),
    .IF_ID_PC_plus4    (pc4),
    .IF_ID_Instruction (instr),
    .WB_RegWrite       (wb_we),
    .WB_WriteReg       (wb_wr),
    .WB_WriteData      (wb_data),
    .EX_MemRead        (ex_mr),
    .EX_RegWrite       (ex_rw),
    .EX_WriteReg       (ex_wr),
    .MEM_MemRead       (mem_mr),
    .MEM_WriteReg      (mem_wr),
    .HoldPC            (hold_pc),
    .Hold_data         (hold_data),
    .IF_ID_Flush       (flush),
    .PCSrc             (pcsrc),
    .branch_target     (target),
    .id_ex             (idex.master)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Control words written out as whole bytes {RegDst..ALUOp}
  function automatic logic [7:0] ctrlTable(input logic [5:0] op);
    case (op)
      6'h00:   return 8'h92;
      6'h23:   return 8'h78;
      6'h2B:   return 8'h44;
      6'h08:   return 8'h50;
      6'h04:   return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] modelRead(input logic [4:0] r);
    if (r == 0) return 32'h0;
    if (wb_we && wb_wr == r) return wb_data;
    return mreg[r];
  endfunction

  task automatic computeExpected();
    logic [5:0] op;
    logic       is_beq, is_j, dep_ex, dep_mem;
    op     = instr[31:26];
    e_rs   = instr[25:21];
    e_rt   = instr[20:16];
    e_rd   = instr[15:11];
    e_pc4  = pc4;
    e_rd1  = modelRead(e_rs);
    e_rd2  = modelRead(e_rt);
    e_imm  = instr[15] ? 32'(instr[15:0]) - 32'h10000 : 32'(instr[15:0]);
    is_beq = (op == 6'h04);
    is_j   = 1'b0;
`ifdef DECODE_JUMP_EN
    is_j   = (op == 6'h02);
`endif
    dep_ex  = (ex_wr != 0)  && (ex_wr == e_rs  || ex_wr == e_rt);
    dep_mem = (mem_wr != 0) && (mem_wr == e_rs || mem_wr == e_rt);
    e_stall = !is_j && ((ex_mr && dep_ex) || (is_beq && ((ex_rw && dep_ex) || (mem_mr && dep_mem))));
    e_pcsrc = is_j || (is_beq && !e_stall && e_rd1 == e_rd2);
    if (is_j) e_target = (pc4 & 32'hF000_0000) + 32'(instr[25:0]) * 4;
    else      e_target = pc4 + e_imm * 4;
    e_ctrl  = e_stall ? 8'h00 : ctrlTable(op);
  endtask

  // Present an instruction and check the combinational outputs
  task automatic applyStimulus(input logic [31:0] i, input logic [31:0] p);
    instr = i;
    pc4   = p;
    #1;
    computeExpected();
    checkVal("HoldPC", {31'b0, hold_pc}, {31'b0, e_stall});
    checkVal("Hold_data", {31'b0, hold_data}, {31'b0, e_stall});
    checkVal("PCSrc", {31'b0, pcsrc}, {31'b0, e_pcsrc});
    checkVal("IF_ID_Flush", {31'b0, flush}, {31'b0, e_pcsrc});
    if (e_pcsrc) checkVal("branch_target", target, e_target);
  endtask

  // Clock the stage and check the ID/EX register
  task automatic checkOutput();
    @(posedge clk);
    #1;
    if (wb_we && wb_wr != 0) mreg[wb_wr] = wb_data;
    checkVal("ID_EX_PC_plus4", idex.ID_EX_PC_plus4, e_pc4);
    checkVal("ID_EX_ReadData1", idex.ID_EX_ReadData1, e_rd1);
    checkVal("ID_EX_ReadData2", idex.ID_EX_ReadData2, e_rd2);
    checkVal("ID_EX_Imm", idex.ID_EX_Imm, e_imm);
    checkVal("ID_EX_Rs", {27'b0, idex.ID_EX_Rs}, {27'b0, e_rs});
    checkVal("ID_EX_Rt", {27'b0, idex.ID_EX_Rt}, {27'b0, e_rt});
    checkVal("ID_EX_Rd", {27'b0, idex.ID_EX_Rd}, {27'b0, e_rd});
    checkVal("ID_EX_Ctrl", {24'b0, idex.ID_EX_Ctrl}, {24'b0, e_ctrl});
  endtask

  task automatic clearSide();
    wb_we = 0; wb_wr = 0; wb_data = 0;
    ex_mr = 0; ex_rw = 0; ex_wr = 0; mem_mr = 0; mem_wr = 0;
  endtask

  task automatic checkIdExZero(input string tag);
    checkVal({tag, "_pc4"},  idex.ID_EX_PC_plus4, 32'h0);
    checkVal({tag, "_rd1"},  idex.ID_EX_ReadData1, 32'h0);
    checkVal({tag, "_imm"},  idex.ID_EX_Imm, 32'h0);
    checkVal({tag, "_ctrl"}, {24'b0, idex.ID_EX_Ctrl}, 32'h0);
  endtask

  initial begin
    logic [5:0] op;
    for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
    rst = 1'b0;
    instr = 32'h00A5_3020; pc4 = 32'h0000_0044;
    clearSide();
    wb_we = 1; wb_wr = 5'd9; wb_data = 32'h5555_AAAA;
    #22;
    checkIdExZero("reset");
    clearSide();
    rst = 1'b1;

    // Any register reads zero after reset
    applyStimulus({6'h00, 5'd9, 5'd10, 5'd11, 11'h020}, 32'h4);
    checkOutput();

    // Writeback bypass into a same-cycle read of rs
    wb_we = 1; wb_wr = 5'd5; wb_data = 32'hDEAD_BEEF;
    applyStimulus({6'h00, 5'd5, 5'd0, 5'd6, 11'h020}, 32'h8);
    checkOutput();
    checkVal("bypass_rd1", idex.ID_EX_ReadData1, 32'hDEAD_BEEF);

    // Write to r0 is dropped
    wb_we = 1; wb_wr = 5'd0; wb_data = 32'h1234_5678;
    applyStimulus({6'h00, 5'd0, 5'd5, 5'd6, 11'h020}, 32'hC);
    checkOutput();
    checkVal("r0_rd1", idex.ID_EX_ReadData1, 32'h0);
    clearSide();

    // Load-use stall, then the same with EX_WriteReg=0
    ex_mr = 1; ex_wr = 5'd8;
    applyStimulus({6'h00, 5'd8, 5'd2, 5'd3, 11'h020}, 32'h10);
    checkVal("loaduse_hold", {31'b0, hold_pc}, 32'h1);
    checkOutput();
    checkVal("loaduse_bubble", {24'b0, idex.ID_EX_Ctrl}, 32'h0);
    ex_wr = 5'd0;
    applyStimulus({6'h00, 5'd0, 5'd2, 5'd3, 11'h020}, 32'h14);
    checkVal("loaduse_r0_hold", {31'b0, hold_pc}, 32'h0);
    checkOutput();
    checkVal("loaduse_r0_ctrl", {24'b0, idex.ID_EX_Ctrl}, 32'h92);
    clearSide();

    // Taken beq with negative offset
    wb_we = 1; wb_wr = 5'd1; wb_data = 32'd7;
    applyStimulus(32'h0, 32'h18); checkOutput();
    wb_wr = 5'd2;
    applyStimulus(32'h0, 32'h1C); checkOutput();
    clearSide();
    applyStimulus(32'h1022_FFFF, 32'h104);
    checkVal("beq_pcsrc", {31'b0, pcsrc}, 32'h1);
    checkVal("beq_target", target, 32'h100);
    checkOutput();
    wb_we = 1; wb_wr = 5'd2; wb_data = 32'd6;
    applyStimulus(32'h0, 32'h20); checkOutput();
    clearSide();
    applyStimulus(32'h1022_FFFF, 32'h104);
    checkVal("beq_ne_pcsrc", {31'b0, pcsrc}, 32'h0);
    checkOutput();

    // Branch hazard on rs=3 from EX, then resolves once the hazard clears
    ex_rw = 1; ex_wr = 5'd3;
    applyStimulus({6'h04, 5'd3, 5'd0, 16'h0004}, 32'h200);
    checkVal("bhaz_hold", {31'b0, hold_data}, 32'h1);
    checkVal("bhaz_pcsrc", {31'b0, pcsrc}, 32'h0);
    checkOutput();
    clearSide();
    applyStimulus({6'h04, 5'd3, 5'd0, 16'h0004}, 32'h200);
    checkVal("bres_pcsrc", {31'b0, pcsrc}, 32'h1);
    checkVal("bres_target", target, 32'h210);
    checkOutput();

    // Jump
    applyStimulus(32'h0800_0010, 32'h4000_0004);
`ifdef DECODE_JUMP_EN
    checkVal("j_pcsrc", {31'b0, pcsrc}, 32'h1);
    checkVal("j_target", target, 32'h4000_0040);
`else
    checkVal("j_pcsrc", {31'b0, pcsrc}, 32'h0);
`endif
    checkOutput();
    checkVal("j_ctrl", {24'b0, idex.ID_EX_Ctrl}, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 7))
        0: op = 6'h00;
        1: op = 6'h23;
        2: op = 6'h2B;
        3: op = 6'h08;
        4, 5: op = 6'h04;
        6: op = 6'h02;
        default: op = 6'($urandom);
      endcase
      wb_we   = ($urandom_range(0, 1) == 1);
      wb_wr   = 5'($urandom_range(0, 7));
      wb_data = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 2)) : $urandom;
      ex_mr   = ($urandom_range(0, 3) == 0);
      ex_rw   = ($urandom_range(0, 2) == 0);
      ex_wr   = 5'($urandom_range(0, 7));
      mem_mr  = ($urandom_range(0, 3) == 0);
      mem_wr  = 5'($urandom_range(0, 7));
      applyStimulus({op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)},
                    $urandom & 32'hFFFF_FFFC);
      checkOutput();
    end

    // Asynchronous reset mid-run clears ID/EX without a clock edge
    clearSide();
    #2;
    rst = 1'b0;
    #1;
    checkIdExZero("async_reset");
    for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus({6'h00, 5'd1, 5'd2, 5'd3, 11'h020}, 32'h300);
    checkOutput();
    checkVal("post_reset_rd1", idex.ID_EX_ReadData1, 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
